// File: rtl/spi_master.sv
// SPI mode-0 initiator, 16-bit frame {addr[6:0], rw, data[7:0]} MSB first; SPI_LOOPBACK_EN samples mosi instead of miso.
// Latency: busy for 34*CLK_DIV cycles, then a one-cycle done. Backpressure: start is ignored while busy.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       sclk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [15:0]     tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rw_q, rw_d;
    logic            done_q, done_d;
    logic            phase_end;
    logic            rx_bit;

    assign phase_end = (cnt_q == CNT_LAST);

`ifdef SPI_LOOPBACK_EN
    // mosi equals tx_q[15] in every phase that precedes a rising SCLK
    logic unused_miso;
    assign unused_miso = miso_i;
    assign rx_bit      = tx_q[15];
`else
    assign rx_bit      = miso_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = {addr_i, rw_i, wdata_i};
                    rw_d    = rw_i;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    rx_d    = {rx_q[6:0], rx_bit};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    tx_d    = {tx_q[14:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bit_q == 5'd16) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_HIGH;
                        rx_d    = {rx_q[6:0], rx_bit};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // the 8-bit rx shifter holds exactly the data-phase bits here
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
        sclk_o = 1'b0;
        cs_o   = 1'b1;
        mosi_o = 1'b0;
        case (state_q)
            S_SETUP, S_LOW: begin
                cs_o   = 1'b0;
                mosi_o = tx_q[15];
            end
            S_HIGH: begin
                cs_o   = 1'b0;
                sclk_o = 1'b1;
                mosi_o = tx_q[15];
            end
            default: ;
        endcase
    end

    assign done_o  = done_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: CLK_DIV=2 and CLK_DIV=1 instances share one peripheral memory model.
// Expected frames, read data, busy and SCLK-high lengths are queued at issue and checked at done.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, rw, miso, sel;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       start0, start1;
    logic       busy0, done0, sclk0, cs0, mosi0;
    logic       busy1, done1, sclk1, cs1, mosi1;
    logic [7:0] rdata0, rdata1;
    logic       p_busy, p_done, p_sclk, p_cs, p_mosi;
    logic [7:0] p_rdata;
    logic       miso_m = 1'b0;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign p_busy  = sel ? busy1  : busy0;
    assign p_done  = sel ? done1  : done0;
    assign p_sclk  = sel ? sclk1  : sclk0;
    assign p_cs    = sel ? cs1    : cs0;
    assign p_mosi  = sel ? mosi1  : mosi0;
    assign p_rdata = sel ? rdata1 : rdata0;
`ifdef SPI_LOOPBACK_EN
    assign miso = 1'b0;
`else
    assign miso = miso_m;
`endif

    spi_master #(.CLK_DIV(2)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start0), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy0), .done_o(done0), .rdata_o(rdata0), .sclk_o(sclk0), .cs_o(cs0), .mosi_o(mosi0),
        .miso_i(miso)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy1), .done_o(done1), .rdata_o(rdata1), .sclk_o(sclk1), .cs_o(cs1), .mosi_o(mosi1),
        .miso_i(miso)
    );

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          busy;
        int          hi;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mem     [128];
    logic [7:0] exp_mem [128];
    logic [7:0] exp_rd  [2];
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Peripheral model plus protocol monitor, all sampled on the falling clk edge.
    int          pbits = 0, last_bits = 0, busy_cnt = 0, hi_cnt = 0, cs_run = 0, last_gap = 0, ndone = 0;
    logic [15:0] shin = '0, last_frame = '0;
    logic [7:0]  pdat = '0;
    logic        prw = 1'b0, unstable = 1'b0;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0, done_prev = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0; hi_cnt = 0; unstable = 1'b0;
        end else begin
            if (p_busy) busy_cnt++;
            if (p_sclk) hi_cnt++;
            if (p_sclk && sclk_prev && p_mosi != mosi_prev) unstable = 1'b1;
        end
        if (p_cs) cs_run++;
        else if (cs_prev) begin last_gap = cs_run; cs_run = 0; end
        if (cs_prev && !p_cs) begin pbits = 0; shin = '0; miso_m = 1'b0; end
        if (!sclk_prev && p_sclk && !p_cs) begin
            shin = {shin[14:0], p_mosi};
            pbits++;
            if (pbits == 8) begin prw = shin[0]; pdat = mem[shin[7:1]]; end
        end
        if (sclk_prev && !p_sclk && !p_cs && pbits >= 8 && pbits < 16)
            miso_m = prw ? pdat[3'(15 - pbits)] : 1'b0;
        if (!cs_prev && p_cs) begin
            last_frame = shin; last_bits = pbits;
            if (pbits == 16 && !shin[8]) mem[shin[15:9]] = shin[7:0];
        end
        if (p_done) begin
            ndone++;
            check_eq("done_width", {31'd0, done_prev}, 0);
            check_eq("sb_nonempty", {31'd0, sbq.size() != 0}, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check_eq("frame", last_frame, e.frame);
                check_eq("frame_bits", last_bits, 16);
                check_eq("rdata", p_rdata, e.rdata);
                check_eq("busy_cycles", busy_cnt, e.busy);
                check_eq("sclk_high_cycles", hi_cnt, e.hi);
                check_eq("mosi_stable", {31'd0, unstable}, 0);
            end
            busy_cnt = 0; hi_cnt = 0; unstable = 1'b0;
        end
        sclk_prev = p_sclk; cs_prev = p_cs; mosi_prev = p_mosi; done_prev = p_done;
    end

    task automatic push_exp(input logic r, input logic [6:0] a, input logic [7:0] d);
        exp_t x;
        int idx = sel ? 1 : 0;
        int div = sel ? 1 : 2;
        if (r) begin
`ifdef SPI_LOOPBACK_EN
            exp_rd[idx] = d;
`else
            exp_rd[idx] = exp_mem[a];
`endif
        end else begin
            exp_mem[a] = d;
        end
        x.frame = {a, r, d};
        x.rdata = exp_rd[idx];
        x.busy  = 34 * div;
        x.hi    = 16 * div;
        sbq.push_back(x);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (p_busy && k < 1000) begin @(negedge clk); k++; end
        check_eq("idle_before_issue", {31'd0, p_busy}, 0);
    endtask

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
        wait_idle();
        rw = r; addr = a; wdata = d; start = 1'b1;
        push_exp(r, a, d);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sbq.size() != 0 && k < 2000) begin @(negedge clk); k++; end
        check_eq("drain", sbq.size(), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        logic [7:0] old;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'(i * 37 + 5);
            exp_mem[i] = mem[i];
        end
        mem[5] = 8'h3C; exp_mem[5] = 8'h3C;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  {busy1, busy0}, 2'b00);
        check_eq("rst_done",  {done1, done0}, 2'b00);
        check_eq("rst_rdata", {rdata1, rdata0}, 16'h0000);
        check_eq("rst_sclk",  {sclk1, sclk0}, 2'b00);
        check_eq("rst_cs",    {cs1, cs0}, 2'b11);
        check_eq("rst_mosi",  {mosi1, mosi0}, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 7'h2A, 8'hA5); wait_done();
        issue(1'b1, 7'h05, 8'h5A); wait_done();
        issue(1'b1, 7'h7F, 8'hC3); wait_done();
        issue(1'b1, 7'h2A, 8'h00); wait_done();

        // start held high across a whole frame: one frame, then the next is taken in the done cycle
        wait_idle();
        n0 = ndone;
        rw = 1'b0; addr = 7'h11; wdata = 8'h77; start = 1'b1;
        push_exp(1'b0, 7'h11, 8'h77);
        @(negedge clk);
        rw = 1'b1; wdata = 8'hEE;
        push_exp(1'b1, 7'h11, 8'hEE);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (p_done) break;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_eq("b2b_done_count", ndone - n0, 2);
        check_eq("b2b_cs_gap_ge2", {31'd0, last_gap >= 2}, 1);

        // reset in the middle of the data phase of a write
        old = exp_mem[7'h33];
        issue(1'b0, 7'h33, 8'h99);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pbits >= 10) break;
        end
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_cs",   {31'd0, cs0}, 1);
        check_eq("midrst_sclk", {31'd0, sclk0}, 0);
        check_eq("midrst_busy", {31'd0, busy0}, 0);
        check_eq("midrst_done", {31'd0, done0}, 0);
        sbq.delete();
        exp_mem[7'h33] = old;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        n0 = ndone;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midrst_no_done", ndone - n0, 0);
        issue(1'b1, 7'h33, 8'h00); wait_done();
        issue(1'b0, 7'h33, 8'h66); wait_done();
        issue(1'b1, 7'h33, 8'h11); wait_done();

        // CLK_DIV=1 instance
        sel = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b1, 7'h2A, 8'h3C); wait_done();
        issue(1'b0, 7'h40, 8'h5E); wait_done();
        issue(1'b1, 7'h40, 8'h81); wait_done();

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
